// File: rtl/usb_pkt_engine.sv
`default_nettype none
// ============================================================================
// Module      : usb_pkt_engine
// Description : Packet stage behind the USB slave-FIFO bridge. It buffers an
//               EP2 payload while summing it, then returns a framed response
//               (length header, payload, checksum) for EP6.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_pkt_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int MAXPKG     = 256,
  parameter int LOGMAXPKG  = 8
) (
  input  logic                  i_usb_ifclk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_last,
  output logic                  o_wr_ready,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_rd_last,
  output logic                  o_busy,
  output logic                  o_overflow
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RECV    = 3'd1;
  localparam logic [2:0] S_HDR     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CSUM    = 3'd4;

  localparam logic [LOGMAXPKG:0] c_MAXPKG    = (LOGMAXPKG+1)'(MAXPKG);
  localparam logic [LOGMAXPKG:0] c_CNT_ONE   = (LOGMAXPKG+1)'(1);
  localparam int                 c_HDR_PAD   = DATA_WIDTH - LOGMAXPKG - 1;

  logic [2:0]            r_state;
  logic [DATA_WIDTH-1:0] r_buff [MAXPKG];
  logic [DATA_WIDTH-1:0] r_mem_q;
  logic [LOGMAXPKG:0]    r_count;
  logic [DATA_WIDTH-1:0] r_sum;
  logic [LOGMAXPKG-1:0]  r_idx;
  logic                  r_overflow;

  logic                  w_wr_ready;
  logic                  w_wr_acc;
  logic                  w_rd_valid;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_store;
  logic [LOGMAXPKG-1:0]  w_waddr;
  logic [LOGMAXPKG-1:0]  w_rd_addr;
  logic                  w_last_idx;

  assign w_wr_ready = (r_state == S_IDLE) || (r_state == S_RECV);
  assign w_wr_acc   = i_wr_en && w_wr_ready;
  assign w_rd_valid = (r_state == S_HDR) || (r_state == S_PAYLOAD) || (r_state == S_CSUM);
  assign w_pop      = i_rd_en && w_rd_valid;
  assign w_full     = (r_count == c_MAXPKG);
  // Words beyond the buffer depth are dropped; only the first word of a
  // packet is written while idle.
  assign w_store    = w_wr_acc && ((r_state == S_IDLE) || ((r_state == S_RECV) && !w_full));
  assign w_waddr    = (r_state == S_IDLE) ? '0 : r_count[LOGMAXPKG-1:0];
  assign w_last_idx = ({1'b0, r_idx} == (r_count - c_CNT_ONE));

  // Read address for the prefetch register: points at the word that must be
  // on the output in the cycle after this one, so consecutive pops never stall.
  always_comb begin
    w_rd_addr = r_idx;
    if (r_state == S_HDR) begin
      w_rd_addr = '0;
    end else if ((r_state == S_PAYLOAD) && w_pop) begin
      w_rd_addr = r_idx + 1'b1;
    end
  end

  // Payload storage with a registered read port (block-RAM friendly).
  always_ff @(posedge i_usb_ifclk) begin
    if (w_store) begin
      r_buff[w_waddr] <= i_wr_data;
    end
    r_mem_q <= r_buff[w_rd_addr];
  end

  // Packet state machine: counts and sums incoming words, then walks the response.
  always_ff @(posedge i_usb_ifclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_sum      <= '0;
      r_idx      <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_acc) begin
            r_count    <= c_CNT_ONE;
            r_sum      <= i_wr_data;
            r_overflow <= 1'b0;
            r_state    <= i_wr_last ? S_HDR : S_RECV;
          end
        end
        S_RECV: begin
          if (w_wr_acc) begin
            if (!w_full) begin
              r_count <= r_count + c_CNT_ONE;
              r_sum   <= r_sum + i_wr_data;
            end else begin
              r_overflow <= 1'b1;
            end
            if (i_wr_last) begin
              r_state <= S_HDR;
            end
          end
        end
        S_HDR: begin
          if (w_pop) begin
            r_idx   <= '0;
            r_state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (w_pop) begin
            if (w_last_idx) begin
              r_state <= S_CSUM;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_CSUM: begin
          if (w_pop) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Response word selection; zero whenever no response word is presented.
  always_comb begin
    o_rd_data = '0;
    case (r_state)
      S_HDR:     o_rd_data = {{c_HDR_PAD{1'b0}}, r_count};
      S_PAYLOAD: o_rd_data = r_mem_q;
      S_CSUM:    o_rd_data = r_sum;
      default:   o_rd_data = '0;
    endcase
  end

  assign o_wr_ready = w_wr_ready;
  assign o_rd_valid = w_rd_valid;
  assign o_rd_last  = (r_state == S_CSUM);
  assign o_busy     = (r_state != S_IDLE);
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_usb_pkt_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_pkt_engine
// Description : Scoreboard bench for usb_pkt_engine. Each scenario task builds
//               a packet, pushes the expected response, and checks the words
//               popped from the engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_pkt_engine;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_wr_en = 1'b0;
  logic [15:0] i_wr_data = '0;
  logic        i_wr_last = 1'b0;
  logic        o_wr_ready;
  logic        i_rd_en = 1'b0;
  logic [15:0] o_rd_data;
  logic        o_rd_valid;
  logic        o_rd_last;
  logic        o_busy;
  logic        o_overflow;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] pkt[$];
  exp_t        exp_q[$];

  usb_pkt_engine #(
    .DATA_WIDTH (16),
    .MAXPKG     (256),
    .LOGMAXPKG  (8)
  ) dut (
    .i_usb_ifclk (clk),
    .i_rst_n     (rst_n),
    .i_wr_en     (i_wr_en),
    .i_wr_data   (i_wr_data),
    .i_wr_last   (i_wr_last),
    .o_wr_ready  (o_wr_ready),
    .i_rd_en     (i_rd_en),
    .o_rd_data   (o_rd_data),
    .o_rd_valid  (o_rd_valid),
    .o_rd_last   (o_rd_last),
    .o_busy      (o_busy),
    .o_overflow  (o_overflow)
  );

  always #5 clk = ~clk;

  // Writes pkt[] with random gaps and queues the expected framed response.
  task automatic send_pkt(input int gap_pct);
    int          n;
    int          stored;
    logic [15:0] sum;
    n      = pkt.size();
    stored = (n > 256) ? 256 : n;
    sum    = '0;
    exp_q.push_back({16'(stored), 1'b0});
    for (int i = 0; i < stored; i++) begin
      sum = sum + pkt[i];
      exp_q.push_back({pkt[i], 1'b0});
    end
    exp_q.push_back({sum, 1'b1});
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      while ($urandom_range(99, 0) < gap_pct) begin
        i_wr_en = 1'b0;
        @(negedge clk);
      end
      checks++;
      if (o_wr_ready !== 1'b1) begin
        errors++;
        $display("FAIL wr_ready_recv word %0d: got %b expected 1", i, o_wr_ready);
      end
      i_wr_en   = 1'b1;
      i_wr_data = pkt[i];
      i_wr_last = (i == n - 1);
    end
    @(negedge clk);
    i_wr_en   = 1'b0;
    i_wr_last = 1'b0;
    checks++;
    if (o_overflow !== (n > 256)) begin
      errors++;
      $display("FAIL overflow_flag: got %b expected %b", o_overflow, (n > 256));
    end
  endtask

  // Pops the response with random stalls, comparing each presented word
  // against the scoreboard head; optionally hammers the write port meanwhile.
  task automatic drain(input int stall_pct, input bit wr_noise);
    int   budget;
    exp_t e;
    budget = 0;
    while (exp_q.size() > 0 && budget < 4000) begin
      if (budget > 0) @(negedge clk);
      budget++;
      if (wr_noise) begin
        i_wr_en   = 1'b1;
        i_wr_data = 16'($urandom);
        i_wr_last = 1'($urandom_range(1, 0));
        checks++;
        if (o_wr_ready !== 1'b0) begin
          errors++;
          $display("FAIL wr_ready_resp: got %b expected 0", o_wr_ready);
        end
      end
      checks++;
      if (o_rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL rd_valid: got %b expected 1 (%0d words left)", o_rd_valid, exp_q.size());
        exp_q.delete();
        break;
      end
      e = exp_q[0];
      checks++;
      if (o_rd_data !== e.d || o_rd_last !== e.l) begin
        errors++;
        $display("FAIL rd_word: got data=%h last=%b expected data=%h last=%b",
                 o_rd_data, o_rd_last, e.d, e.l);
      end
      if ($urandom_range(99, 0) >= stall_pct) begin
        i_rd_en = 1'b1;
        void'(exp_q.pop_front());
      end else begin
        i_rd_en = 1'b0;
      end
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    i_rd_en   = 1'b0;
    i_wr_en   = 1'b0;
    i_wr_last = 1'b0;
    checks++;
    if (o_rd_valid !== 1'b0 || o_wr_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_response: got valid=%b ready=%b busy=%b expected 0/1/0",
               o_rd_valid, o_wr_ready, o_busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_wr_ready !== 1'b1 || o_rd_valid !== 1'b0 ||
        o_rd_last !== 1'b0 || o_overflow !== 1'b0 || o_rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: got busy=%b ready=%b valid=%b last=%b ovf=%b data=%h",
               o_busy, o_wr_ready, o_rd_valid, o_rd_last, o_overflow, o_rd_data);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_wr_en   = 1'b1;
      i_wr_data = 16'h1000 + 16'(i);
      i_wr_last = 1'b0;
    end
    @(negedge clk);
    i_wr_en = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_recv: got %b expected 1", o_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_wr_ready !== 1'b1 || o_rd_valid !== 1'b0 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b ready=%b valid=%b ovf=%b expected 0/1/0/0",
               o_busy, o_wr_ready, o_rd_valid, o_overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pkt = '{16'hA5A5, 16'h1234};
    send_pkt(0);
    drain(0, 1'b0);
  endtask

  task automatic test_basic();
    pkt = '{16'h0001, 16'h0002, 16'h0003};
    send_pkt(0);
    drain(0, 1'b0);
  endtask

  task automatic test_single_and_wrap();
    pkt = '{16'hFFFF};
    send_pkt(0);
    drain(0, 1'b0);
    pkt = '{16'hFFFF, 16'h0002};
    send_pkt(0);
    drain(0, 1'b0);
  endtask

  task automatic test_overflow();
    pkt.delete();
    for (int i = 0; i < 258; i++) pkt.push_back(16'h0001);
    send_pkt(0);
    drain(0, 1'b0);
  endtask

  task automatic test_gaps_stalls();
    pkt.delete();
    for (int i = 0; i < 20; i++) pkt.push_back(16'($urandom));
    send_pkt(0);
    drain(0, 1'b0);
    send_pkt(40);
    drain(50, 1'b0);
  endtask

  task automatic test_write_during_response();
    pkt = '{16'h0BAD, 16'hCAFE, 16'h0042, 16'h7777};
    send_pkt(0);
    drain(30, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 3; p++) begin
      pkt.delete();
      for (int i = 0; i < 5 + p; i++) pkt.push_back(16'($urandom));
      send_pkt(0);
      drain(0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_and_wrap();
    test_overflow();
    test_gaps_stalls();
    test_write_during_response();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
